// File: rtl/location_to_vector_if.sv
// Location-beat input stream and reconstructed-vector result stream.
interface location_to_vector_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_vld;
    logic             in_rdy;
    logic [15:0]      location;
    logic             in_last;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] vector;
    logic [15:0]      beat_cnt;
    logic             dup;
    logic             range_err;

    // Producer of location beats and consumer of results.
    modport master (
        output in_vld, location, in_last, out_rdy,
        input  in_rdy, out_vld, vector, beat_cnt, dup, range_err
    );

    // The reconstruction block.
    modport slave (
        input  in_vld, location, in_last, out_rdy,
        output in_rdy, out_vld, vector, beat_cnt, dup, range_err
    );
endinterface

// File: rtl/location_to_vector.sv
// Rebuilds a WIDTH-bit vector from a framed stream of bit locations and
// reports per-frame beat count, duplicate hits and out-of-range locations.
module location_to_vector #(
    parameter int unsigned WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    location_to_vector_if.slave bus
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Locations are 16 bits wide, so wider vectors cannot be fully addressed.
    if (WIDTH < 1 || WIDTH > 65536) begin : g_width_check
        $error("location_to_vector: WIDTH must be in 1..65536");
    end

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [15:0]      cnt;
    logic             dup_acc;
    logic             rerr_acc;

    logic             accept_c;
    logic             in_range_c;
    logic [WIDTH-1:0] mask_c;
    logic [WIDTH-1:0] base_c;
    logic [15:0]      cnt_base_c;
    logic [15:0]      cnt_inc_c;
    logic             hit_c;

    // Hold-off only while an unconsumed result is pending.
    assign bus.in_rdy = !bus.out_vld || bus.out_rdy;
    assign accept_c   = bus.in_vld && bus.in_rdy;

    // Full 16-bit range compare; out-of-range beats contribute no bit.
    assign in_range_c = 32'(bus.location) < WIDTH;
    assign mask_c     = in_range_c ? (WIDTH'(1) << bus.location[IDX_W-1:0]) : '0;

    // Partial-frame state is only meaningful while accumulating.
    assign base_c     = (state == ACCUM) ? acc : '0;
    assign cnt_base_c = (state == ACCUM) ? cnt : 16'd0;
    assign hit_c      = |(base_c & mask_c);
    assign cnt_inc_c  = (cnt_base_c == 16'hFFFF) ? cnt_base_c : cnt_base_c + 16'd1;

    // Frame accumulation, result registers and consume handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= 16'd0;
            dup_acc       <= 1'b0;
            rerr_acc      <= 1'b0;
            bus.out_vld   <= 1'b0;
            bus.vector    <= '0;
            bus.beat_cnt  <= 16'd0;
            bus.dup       <= 1'b0;
            bus.range_err <= 1'b0;
        end else begin
            if (accept_c) begin
                if (bus.in_last) begin
                    bus.vector    <= base_c | mask_c;
                    bus.beat_cnt  <= cnt_inc_c;
                    bus.dup       <= ((state == ACCUM) && dup_acc) || hit_c;
                    bus.range_err <= ((state == ACCUM) && rerr_acc) || !in_range_c;
                    bus.out_vld   <= 1'b1;
                    acc           <= '0;
                    cnt           <= 16'd0;
                    dup_acc       <= 1'b0;
                    rerr_acc      <= 1'b0;
                    state         <= IDLE;
                end else begin
                    acc           <= base_c | mask_c;
                    cnt           <= cnt_inc_c;
                    dup_acc       <= ((state == ACCUM) && dup_acc) || hit_c;
                    rerr_acc      <= ((state == ACCUM) && rerr_acc) || !in_range_c;
                    state         <= ACCUM;
                    if (bus.out_rdy) begin
                        bus.out_vld <= 1'b0;
                    end
                end
            end else if (bus.out_vld && bus.out_rdy) begin
                bus.out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_location_to_vector.sv
// Directed bench for location_to_vector with WIDTH=8.
module tb_location_to_vector;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [15:0] loc;
        logic        last;
        logic [7:0]  e_vec;
        logic [15:0] e_cnt;
        logic        e_dup;
        logic        e_rerr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t tbl[$];

    location_to_vector_if #(.WIDTH(WIDTH)) bus ();

    location_to_vector #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [15:0] loc, input logic last, input logic [7:0] e_vec,
                       input logic [15:0] e_cnt, input logic e_dup, input logic e_rerr);
        vec_t v;
        v.loc = loc; v.last = last; v.e_vec = e_vec;
        v.e_cnt = e_cnt; v.e_dup = e_dup; v.e_rerr = e_rerr;
        tbl.push_back(v);
    endtask

    task automatic check_result(input string tag, input logic [7:0] e_vec, input logic [15:0] e_cnt,
                                input logic e_dup, input logic e_rerr);
        check({tag, ".vector"}, 32'(bus.vector), 32'(e_vec));
        check({tag, ".beat_cnt"}, 32'(bus.beat_cnt), 32'(e_cnt));
        check({tag, ".dup"}, 32'(bus.dup), 32'(e_dup));
        check({tag, ".range_err"}, 32'(bus.range_err), 32'(e_rerr));
    endtask

    // Drive one beat at the current negedge; it is taken at the next posedge.
    task automatic beat(input logic [15:0] loc, input logic last);
        bus.in_vld   = 1'b1;
        bus.location = loc;
        bus.in_last  = last;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n        = 1'b0;
        bus.in_vld   = 1'b0;
        bus.location = 16'd0;
        bus.in_last  = 1'b0;
        bus.out_rdy  = 1'b1;

        // Frames run back to back with the consumer always ready.
        add(16'd3,     1'b1, 8'h08, 16'd1, 1'b0, 1'b0);
        add(16'd0,     1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
        add(16'd7,     1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
        add(16'd2,     1'b1, 8'h85, 16'd3, 1'b0, 1'b0);
        add(16'd5,     1'b1, 8'h20, 16'd1, 1'b0, 1'b0);
        add(16'd4,     1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
        add(16'd4,     1'b1, 8'h10, 16'd2, 1'b1, 1'b0);
        add(16'd1,     1'b1, 8'h02, 16'd1, 1'b0, 1'b0);
        add(16'd9,     1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
        add(16'd1,     1'b1, 8'h02, 16'd2, 1'b0, 1'b1);
        add(16'd8,     1'b1, 8'h00, 16'd1, 1'b0, 1'b1);
        add(16'd7,     1'b1, 8'h80, 16'd1, 1'b0, 1'b0);
        add(16'hFFFF,  1'b1, 8'h00, 16'd1, 1'b0, 1'b1);
        add(16'h0100,  1'b1, 8'h00, 16'd1, 1'b0, 1'b1);
        add(16'd0,     1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
        add(16'd0,     1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
        add(16'd0,     1'b1, 8'h01, 16'd3, 1'b1, 1'b0);

        #12;
        check("reset.out_vld", 32'(bus.out_vld), 32'd0);
        check("reset.in_rdy", 32'(bus.in_rdy), 32'd1);
        check_result("reset", 8'h00, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: out_vld follows in_last of the previous beat; results on last beats.
        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("tbl%0d.in_rdy", i), 32'(bus.in_rdy), 32'd1);
            beat(tbl[i].loc, tbl[i].last);
            check($sformatf("tbl%0d.out_vld", i), 32'(bus.out_vld), 32'(tbl[i].last));
            if (tbl[i].last)
                check_result($sformatf("tbl%0d", i), tbl[i].e_vec, tbl[i].e_cnt,
                             tbl[i].e_dup, tbl[i].e_rerr);
        end

        // Consume with no new frame: out_vld drops, result registers hold.
        bus.in_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drain.out_vld", 32'(bus.out_vld), 32'd0);
        check_result("drain", 8'h01, 16'd3, 1'b1, 1'b0);

        // Backpressure: pending result blocks every new beat.
        bus.out_rdy = 1'b0;
        beat(16'd6, 1'b1);
        bus.location = 16'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("hold%0d.in_rdy", c), 32'(bus.in_rdy), 32'd0);
            check($sformatf("hold%0d.out_vld", c), 32'(bus.out_vld), 32'd1);
            check_result($sformatf("hold%0d", c), 8'h40, 16'd1, 1'b0, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_rdy = 1'b1;
        #1;
        check("release.in_rdy", 32'(bus.in_rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_vld = 1'b0;
        check("release.out_vld", 32'(bus.out_vld), 32'd1);
        check_result("release", 8'h04, 16'd1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset mid-frame discards the partial frame.
        beat(16'd3, 1'b0);
        beat(16'd5, 1'b0);
        bus.in_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.out_vld", 32'(bus.out_vld), 32'd0);
        check_result("midrst", 8'h00, 16'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        beat(16'd1, 1'b1);
        check("postrst.out_vld", 32'(bus.out_vld), 32'd1);
        check_result("postrst", 8'h02, 16'd1, 1'b0, 1'b0);

        // Beat counter saturates on a 65537-beat frame.
        for (int n = 0; n < 65536; n++) beat(16'd0, 1'b0);
        beat(16'd1, 1'b1);
        bus.in_vld = 1'b0;
        check("sat.out_vld", 32'(bus.out_vld), 32'd1);
        check_result("sat", 8'h03, 16'hFFFF, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
